// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: round-robin burst arbiter for the async FIFO write port (wr_clk domain).
// Define WR_ARB_STATS_EN to build the per-requester accepted-beat counters.
module wr_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          wr_clk,
   input  logic                          wr_rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wr_full,
   output logic                          wr_en,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy,
   input  logic [ID_WIDTH-1:0]           stat_sel,
   output logic [15:0]                   stat_count
);

   // state | meaning
   // IDLE  | no owner; next requester picked round-robin starting at rr_ptr
   // BURST | grant_id owns the write port until its last beat or MAX_BURST beats
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   localparam int                  BC_W    = $clog2(MAX_BURST) + 1;
   localparam logic [BC_W-1:0]     BC_LAST = BC_W'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0] ID_MAX  = ID_WIDTH'(NUM_REQ - 1);

   logic [0:0]            state;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [BC_W-1:0]       beat_cnt;

   logic [NUM_REQ-1:0]    gnt_onehot;
   logic                  g_valid;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  any_valid;
   logic [ID_WIDTH-1:0]   pick_id;
   logic                  accept;
   logic                  burst_end;

   always_comb begin
      gnt_onehot = '0;
      g_valid    = 1'b0;
      g_last     = 1'b0;
      g_data     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            gnt_onehot[i] = 1'b1;
            g_valid       = req_valid[i];
            g_last        = req_last[i];
            g_data        = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Scan offsets from far to near so the nearest valid index at/after rr_ptr wins.
   always_comb begin
      int idx;
      idx       = 0;
      any_valid = |req_valid;
      pick_id   = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == i && req_valid[i]) pick_id = ID_WIDTH'(i);
         end
      end
   end

   assign busy      = (state == BURST);
   assign accept    = busy & g_valid & ~wr_full;
   assign burst_end = accept & (g_last | (beat_cnt == BC_LAST));
   assign req_ready = (busy & ~wr_full) ? gnt_onehot : '0;
   assign wr_en     = accept;
   assign wr_data   = accept ? g_data : '0;

   always_ff @(posedge wr_clk or negedge wr_rstn) begin
      if (!wr_rstn) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (any_valid) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= BURST;
         end
      end else begin
         if (burst_end) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

`ifdef WR_ARB_STATS_EN
   logic [15:0] stat_cnt [NUM_REQ];

   always_ff @(posedge wr_clk or negedge wr_rstn) begin
      if (!wr_rstn) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && gnt_onehot[i] && stat_cnt[i] != 16'hFFFF)
               stat_cnt[i] <= stat_cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel == ID_WIDTH'(i)) stat_count = stat_cnt[i];
      end
   end
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_count      = 16'h0;
`endif

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter: directed + randomized bench for wr_port_arbiter against a
// transaction-level round-robin model (requester beat queues, owner/pointer integers).
module tb_wr_port_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int MAXB = 16;
   localparam int IDW  = 2;

   logic             wr_clk = 1'b0;
   logic             wr_rstn = 1'b0;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_last;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]  req_ready;
   logic             wr_full;
   logic             wr_en;
   logic [DW-1:0]    wr_data;
   logic [IDW-1:0]   grant_id;
   logic             busy;
   logic [IDW-1:0]   stat_sel;
   logic [15:0]      stat_count;

   int vec_cnt = 0;
   int miscompares = 0;

   always #5 wr_clk = ~wr_clk;

   wr_port_arbiter #(
      .NUM_REQ    (NREQ),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MAXB),
      .ID_WIDTH   (IDW)
   ) dut (
      .wr_clk     (wr_clk),
      .wr_rstn    (wr_rstn),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .wr_full    (wr_full),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .grant_id   (grant_id),
      .busy       (busy),
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
   );

   // requester beat queues: {last, data}
   logic [8:0] bq [NREQ][$];
   logic [7:0] dut_log [$];

   int owner;
   int ptr;
   int beats;
   int last_grant;
   int st [NREQ];
   bit rand_mode;
   bit full_force;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit vbit(input logic [NREQ-1:0] v, input int i);
      return ((v >> i) & NREQ'(1)) != '0;
   endfunction

   function automatic bit pending();
      for (int i = 0; i < NREQ; i++) if (bq[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      owner = -1;
      ptr = 0;
      beats = 0;
      last_grant = 0;
      for (int i = 0; i < NREQ; i++) st[i] = 0;
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NREQ; i++) bq[i].delete();
   endtask

   task automatic drive_inputs();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (bq[i].size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
            req_valid = req_valid | (NREQ'(1) << i);
            if (bq[i][0][8]) req_last = req_last | (NREQ'(1) << i);
            req_data = req_data | ((NREQ*DW)'(bq[i][0][7:0]) << (i*DW));
         end
      end
      wr_full  = rand_mode ? ($urandom_range(0, 6) == 0) : full_force;
      stat_sel = IDW'($urandom_range(0, NREQ - 1));
   endtask

   task automatic compare_outputs();
      logic [NREQ-1:0] e_ready;
      logic            e_en;
      logic [15:0]     e_stat;
      e_ready = '0;
      e_en    = 1'b0;
      if (owner >= 0 && !wr_full) begin
         e_ready = NREQ'(1) << owner;
         e_en    = vbit(req_valid, owner);
      end
      check_val("req_ready", 32'(req_ready), 32'(e_ready));
      check_val("wr_en", 32'(wr_en), 32'(e_en));
      check_val("busy", 32'(busy), 32'(owner >= 0));
      check_val("grant_id", 32'(grant_id), 32'(last_grant));
      if (e_en) check_val("wr_data", 32'(wr_data), 32'(8'(req_data >> (owner*DW))));
      else if (owner < 0) check_val("wr_data_idle", 32'(wr_data), 32'(0));
`ifdef WR_ARB_STATS_EN
      e_stat = 16'(st[int'(stat_sel)]);
`else
      e_stat = 16'h0;
`endif
      check_val("stat_count", 32'(stat_count), 32'(e_stat));
      if (wr_en) dut_log.push_back(wr_data);
   endtask

   task automatic model_update();
      logic [8:0] b;
      bit found;
      found = 1'b0;
      if (owner < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (!found && vbit(req_valid, i)) begin
               found = 1'b1;
               owner = i;
               last_grant = i;
               beats = 0;
            end
         end
      end else if (vbit(req_valid, owner) && !wr_full) begin
         b = bq[owner].pop_front();
         if (st[owner] < 65535) st[owner]++;
         beats++;
         if (b[8] || beats == MAXB) begin
            ptr = (owner + 1) % NREQ;
            owner = -1;
            beats = 0;
         end
      end
   endtask

   task automatic tick();
      drive_inputs();
      @(negedge wr_clk);
      compare_outputs();
      model_update();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic run_drain(input int budget, input string tag);
      int n;
      n = 0;
      while ((pending() || owner >= 0) && n < budget) begin
         tick();
         n++;
      end
      if (pending() || owner >= 0) check_val({tag, "_timeout"}, 32'(1), 32'(0));
   endtask

   task automatic do_reset();
      wr_rstn = 1'b0;
      @(negedge wr_clk);
      model_reset();
      clear_queues();
      drive_inputs();
      compare_outputs();
      wr_rstn = 1'b1;
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int sz;
      rand_mode  = 1'b0;
      full_force = 1'b0;
      model_reset();
      clear_queues();
      drive_inputs();
      repeat (3) @(posedge wr_clk);
      @(negedge wr_clk);
      compare_outputs();
      wr_rstn = 1'b1;
      @(posedge wr_clk);
      #1;

      // 1: idle after reset
      repeat (20) tick();

      // 2: three simultaneous 3-beat bursts, round-robin order
      dut_log.delete();
      for (int k = 0; k < 3; k++) begin
         bq[0].push_back({k == 2, 8'(8'hA0 + k)});
         bq[1].push_back({k == 2, 8'(8'hB0 + k)});
         bq[2].push_back({k == 2, 8'(8'hC0 + k)});
      end
      run_drain(60, "t2");
      check_val("t2_count", 32'(dut_log.size()), 32'(9));
      for (int j = 0; j < 9; j++) begin
         if (j < dut_log.size())
            check_val($sformatf("t2_beat%0d", j), 32'(dut_log[j]),
                      32'(8'hA0 + (j / 3) * 16 + (j % 3)));
      end
      bq[0].push_back({1'b1, 8'h01});
      bq[3].push_back({1'b1, 8'h03});
      tick();
      check_val("t2_rr_ptr_3", 32'(grant_id), 32'(3));
      run_drain(20, "t2b");

      // 3: forced end at MAX_BURST, req1 resumes after req2
      dut_log.delete();
      for (int k = 0; k < 40; k++) bq[1].push_back({k == 39, 8'(64 + k)});
      for (int k = 0; k < 16; k++) bq[2].push_back({k == 15, 8'(128 + k)});
      run_drain(200, "t3");
      check_val("t3_count", 32'(dut_log.size()), 32'(56));
      if (dut_log.size() == 56) begin
         check_val("t3_req1_first", 32'(dut_log[0]),  32'(64));
         check_val("t3_req1_cut",   32'(dut_log[15]), 32'(79));
         check_val("t3_req2_first", 32'(dut_log[16]), 32'(128));
         check_val("t3_req2_last",  32'(dut_log[31]), 32'(143));
         check_val("t3_req1_resume",32'(dut_log[32]), 32'(80));
         check_val("t3_req1_end",   32'(dut_log[55]), 32'(103));
      end

      // 4: wr_full for 5 cycles after beat 2
      dut_log.delete();
      for (int k = 0; k < 6; k++) bq[0].push_back({k == 5, 8'(8'hC0 + k)});
      n = 0;
      while (!(owner == 0 && beats == 2) && n < 20) begin tick(); n++; end
      check_val("t4_reach_beat2", 32'(owner == 0 && beats == 2), 32'(1));
      sz = dut_log.size();
      full_force = 1'b1;
      repeat (5) tick();
      check_val("t4_no_write_full", 32'(dut_log.size() - sz), 32'(0));
      full_force = 1'b0;
      tick();
      check_val("t4_resume_beat3", 32'(dut_log.size() == 3 ? dut_log[2] : 8'h00), 32'(8'hC2));
      run_drain(20, "t4");
      check_val("t4_count", 32'(dut_log.size()), 32'(6));
      for (int j = 0; j < 6; j++)
         if (j < dut_log.size())
            check_val($sformatf("t4_beat%0d", j), 32'(dut_log[j]), 32'(8'hC0 + j));

      // 5: reset during beat 2, arbitration restarts at requester 0
      for (int k = 0; k < 5; k++) bq[2].push_back({k == 4, 8'(8'hD0 + k)});
      n = 0;
      while (!(owner == 2 && beats == 1) && n < 20) begin tick(); n++; end
      check_val("t5_reach_beat2", 32'(owner == 2 && beats == 1), 32'(1));
      wr_rstn = 1'b0;
      @(negedge wr_clk);
      model_reset();
      compare_outputs();
      check_val("t5_rst_ready", 32'(req_ready), 32'(0));
      clear_queues();
      drive_inputs();
      wr_rstn = 1'b1;
      @(posedge wr_clk);
      #1;
      bq[0].push_back({1'b0, 8'h11});
      bq[0].push_back({1'b1, 8'h12});
      bq[3].push_back({1'b0, 8'h31});
      bq[3].push_back({1'b1, 8'h32});
      tick();
      check_val("t5_restart_grant", 32'(grant_id), 32'(0));
      run_drain(30, "t5");

      // randomized traffic with valid gaps and backpressure
      rand_mode = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 24);
               for (int k = 0; k < len; k++)
                  bq[i].push_back({k == len - 1, 8'($urandom_range(0, 255))});
            end
         end
         tick();
      end
      rand_mode = 1'b0;
      run_drain(600, "rand");

      // 6: stats counters
`ifdef WR_ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 65600; k++) bq[3].push_back({k == 65599, 8'(k)});
      run_drain(72000, "t6");
      for (int s = 0; s < NREQ; s++) begin
         stat_sel = IDW'(s);
         #1;
         check_val($sformatf("t6_stat%0d", s), 32'(stat_count), (s == 3) ? 32'hFFFF : 32'h0);
      end
`else
      for (int s = 0; s < NREQ; s++) begin
         stat_sel = IDW'(s);
         #1;
         check_val($sformatf("t6_stat_off%0d", s), 32'(stat_count), 32'h0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end
endmodule
